// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer write path.
package fb_pkg;

  localparam int H_RES     = 320;
  localparam int V_RES     = 240;
  localparam int ADDR_W    = 17;
  localparam int PIX_W     = 3;
  localparam int FRAME_PIX = H_RES * V_RES;

  typedef enum logic {IDLE, CLEAR} fbw_state_t;

  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to its linear frame-buffer address and flags
// coordinates that fall outside the visible frame.
module fb_addr_calc
  import fb_pkg::*;
#(
  parameter int LINE_PIX = fb_pkg::H_RES,
  parameter int LINE_CNT = fb_pkg::V_RES,
  parameter int AW       = fb_pkg::ADDR_W
) (
  input  logic [8:0]    x,
  input  logic [7:0]    y,
  output logic          in_range,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] y_ext;
  logic [AW-1:0] x_ext;

  assign y_ext    = AW'(y);
  assign x_ext    = AW'(x);
  assign in_range = (int'(x) < LINE_PIX) && (int'(y) < LINE_CNT);

  // 320 = 256 + 64, so the default line width needs only two shifts and adds.
  generate
    if (LINE_PIX == 320) begin : g_shift_add
      assign addr = (y_ext << 8) + (y_ext << 6) + x_ext;
    end else begin : g_multiply
      assign addr = (y_ext * AW'(LINE_PIX)) + x_ext;
    end
  endgenerate

endmodule

// File: rtl/fb_pixel_writer.sv
// Write-side frame-buffer controller: single-pixel writes from (x,y,colour)
// requests plus a full-frame fill with a single colour.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int V_RES  = fb_pkg::V_RES,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [8:0]        req_x,
  input  logic [7:0]        req_y,
  input  pixel_t            req_color,
  input  logic              clear_start,
  input  pixel_t            clear_color,
  output logic [ADDR_W-1:0] wAddr,
  output pixel_t            wData,
  output logic              wEn,
  output logic              busy,
  output logic              clear_done,
  output logic              err_oob
);

  localparam int                FRAME     = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

  fbw_state_t        state, next_state;
  logic [ADDR_W-1:0] fill_cnt, fill_d;
  pixel_t            fill_color, color_d;
  logic [ADDR_W-1:0] addr_d;
  pixel_t            data_d;
  logic              wen_d, busy_d, done_d, oob_d;
  logic              in_range;
  logic [ADDR_W-1:0] pix_addr;

  fb_addr_calc #(
    .LINE_PIX (H_RES),
    .LINE_CNT (V_RES),
    .AW       (ADDR_W)
  ) u_addr_calc (
    .x        (req_x),
    .y        (req_y),
    .in_range (in_range),
    .addr     (pix_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Outputs are registered in step with the state, so the last fill write
  // shares its cycle with CLEAR and clear_done lands on the first IDLE cycle.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    fill_d     = fill_cnt;
    color_d    = fill_color;
    addr_d     = wAddr;
    data_d     = wData;
    wen_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    oob_d      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !clear_start;
        if (clear_start) begin
          next_state = CLEAR;
          color_d    = clear_color;
          fill_d     = '0;
          wen_d      = 1'b1;
          addr_d     = '0;
          data_d     = clear_color;
          busy_d     = 1'b1;
        end else if (req_valid) begin
          if (in_range) begin
            wen_d  = 1'b1;
            addr_d = pix_addr;
            data_d = req_color;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (fill_cnt == LAST_ADDR) begin
          next_state = IDLE;
          done_d     = 1'b1;
        end else begin
          fill_d = fill_cnt + ADDR_W'(1);
          wen_d  = 1'b1;
          addr_d = fill_cnt + ADDR_W'(1);
          data_d = fill_color;
          busy_d = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_cnt   <= '0;
      fill_color <= '0;
      wAddr      <= '0;
      wData      <= '0;
      wEn        <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      fill_cnt   <= fill_d;
      fill_color <= color_d;
      wAddr      <= addr_d;
      wData      <= data_d;
      wEn        <= wen_d;
      busy       <= busy_d;
      clear_done <= done_d;
      err_oob    <= oob_d;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: table-driven pixel writes plus
// directed reset and full-frame fill sequences.
module tb_fb_pixel_writer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_x;
  logic [7:0]  req_y;
  logic [2:0]  req_color;
  logic        clear_start;
  logic [2:0]  clear_color;
  logic [16:0] wAddr;
  logic [2:0]  wData;
  logic        wEn;
  logic        busy;
  logic        clear_done;
  logic        err_oob;

  int tests  = 0;
  int failed = 0;

  fb_pixel_writer dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .wAddr       (wAddr),
    .wData       (wData),
    .wEn         (wEn),
    .busy        (busy),
    .clear_done  (clear_done),
    .err_oob     (err_oob)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  color;
    logic        exp_wen;
    logic [16:0] exp_addr;
    logic [2:0]  exp_data;
    logic        exp_oob;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [8:0] x,
                               input logic [7:0] y, input logic [2:0] color);
    req_valid = valid;
    req_x     = x;
    req_y     = y;
    req_color = color;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int fill_errs;
    reset       = 1'b1;
    clear_start = 1'b0;
    clear_color = 3'b000;
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0);

    vecs[0]  = '{1'b1, 9'd5,   8'd2,   3'b101, 1'b1, 17'd645,   3'b101, 1'b0};
    vecs[1]  = '{1'b0, 9'd0,   8'd0,   3'b000, 1'b0, 17'd645,   3'b101, 1'b0};
    vecs[2]  = '{1'b1, 9'd0,   8'd0,   3'b001, 1'b1, 17'd0,     3'b001, 1'b0};
    vecs[3]  = '{1'b1, 9'd319, 8'd0,   3'b010, 1'b1, 17'd319,   3'b010, 1'b0};
    vecs[4]  = '{1'b1, 9'd0,   8'd239, 3'b011, 1'b1, 17'd76480, 3'b011, 1'b0};
    vecs[5]  = '{1'b1, 9'd319, 8'd239, 3'b111, 1'b1, 17'd76799, 3'b111, 1'b0};
    vecs[6]  = '{1'b1, 9'd320, 8'd10,  3'b100, 1'b0, 17'd76799, 3'b111, 1'b1};
    vecs[7]  = '{1'b0, 9'd0,   8'd0,   3'b000, 1'b0, 17'd76799, 3'b111, 1'b0};
    vecs[8]  = '{1'b1, 9'd3,   8'd240, 3'b110, 1'b0, 17'd76799, 3'b111, 1'b1};
    vecs[9]  = '{1'b1, 9'd511, 8'd255, 3'b001, 1'b0, 17'd76799, 3'b111, 1'b1};
    vecs[10] = '{1'b1, 9'd10,  8'd1,   3'b100, 1'b1, 17'd330,   3'b100, 1'b0};
    vecs[11] = '{1'b0, 9'd0,   8'd0,   3'b000, 1'b0, 17'd330,   3'b100, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    checkOutput("por_wEn", wEn, 0);
    checkOutput("por_wAddr", wAddr, 0);
    reset = 1'b0;
    #1;
    checkOutput("por_ready", req_ready, 1);

    // Single writes, corner addresses and out-of-range discards.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].x, vecs[i].y, vecs[i].color);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), req_ready, 1);
      nextCycle();
      checkOutput($sformatf("vec%0d_wEn", i), wEn, vecs[i].exp_wen);
      checkOutput($sformatf("vec%0d_wAddr", i), wAddr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_wData", i), wData, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_err_oob", i), err_oob, vecs[i].exp_oob);
      checkOutput($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Mid-simulation asynchronous reset.
    reset = 1'b1;
    #1;
    checkOutput("rst_wEn", wEn, 0);
    checkOutput("rst_wAddr", wAddr, 0);
    checkOutput("rst_wData", wData, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clear_done", clear_done, 0);
    checkOutput("rst_err_oob", err_oob, 0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", req_ready, 1);

    // Full-frame fill with a request held throughout.
    applyStimulus(1'b1, 9'd7, 8'd1, 3'b110);
    clear_color = 3'b010;
    clear_start = 1'b1;
    #1;
    checkOutput("clr_start_ready", req_ready, 0);
    nextCycle();
    clear_start = 1'b0;
    clear_color = 3'b000;
    #1;
    checkOutput("clr_busy_ready", req_ready, 0);
    fill_errs = 0;
    for (int i = 0; i < 76800; i++) begin
      tests++;
      if (wEn !== 1'b1 || wAddr !== 17'(i) || wData !== 3'b010 ||
          busy !== 1'b1 || clear_done !== 1'b0) begin
        failed++;
        if (fill_errs < 5)
          $display("[TB] FAIL fill_%0d: got wEn=%0d wAddr=%0d wData=%0d busy=%0d done=%0d, expected 1 %0d 2 1 0",
                   i, wEn, wAddr, wData, busy, clear_done, i);
        fill_errs++;
      end
      if (i == 100) begin
        clear_start = 1'b1;
        clear_color = 3'b111;
      end else begin
        clear_start = 1'b0;
        clear_color = 3'b000;
      end
      nextCycle();
    end
    checkOutput("clr_done_pulse", clear_done, 1);
    checkOutput("clr_done_busy", busy, 0);
    checkOutput("clr_done_wEn", wEn, 0);
    checkOutput("clr_done_ready", req_ready, 1);
    nextCycle();
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0);
    checkOutput("held_req_wEn", wEn, 1);
    checkOutput("held_req_wAddr", wAddr, 327);
    checkOutput("held_req_wData", wData, 3'b110);
    checkOutput("held_req_done_low", clear_done, 0);

    // Reset partway through a fill; the next fill starts from zero.
    clear_color = 3'b101;
    clear_start = 1'b1;
    nextCycle();
    clear_start = 1'b0;
    repeat (1000) @(posedge clock);
    #1;
    checkOutput("abort_pre_wAddr", wAddr, 1000);
    checkOutput("abort_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_wEn", wEn, 0);
    checkOutput("abort_busy", busy, 0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("abort_ready", req_ready, 1);
    clear_color = 3'b011;
    clear_start = 1'b1;
    nextCycle();
    clear_start = 1'b0;
    checkOutput("restart_wEn", wEn, 1);
    checkOutput("restart_wAddr", wAddr, 0);
    checkOutput("restart_wData", wData, 3'b011);
    nextCycle();
    checkOutput("restart_wAddr1", wAddr, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
